// File: rtl/led_breath_seq.sv
// led_breath_seq
// Multi-channel breathing-LED sequencer. A 1 us prescaler drives a PWM period
// counter. A shared duty value ramps up, holds fully on, ramps down, and then
// holds fully off. All LEDs can breathe in phase (mode 0), or the breath can
// step from one channel to the next after each complete breath (mode 1).
//
// Ports:
//   s_clk   system clock, all logic on the rising edge
//   s_rst   synchronous reset, active-high
//   start   one-cycle pulse; starts the sequence when idle
//   stop    one-cycle pulse; aborts from any state (wins over start)
//   mode    0 = in phase, 1 = chase; sampled only on an accepted start
//   led     LED drive, active-low, registered one cycle after the counters
//   ch_sel  one-hot active channel used in chase mode
//   busy    high whenever the sequencer is not idle
//
// Build option: define LED_BREATH_GAMMA_EN to use the quadratic compare
// pwm_cnt*PWM_STEPS < duty*duty instead of the linear pwm_cnt < duty.
//
// state   | meaning
// IDLE    | outputs dark, counters held at zero, waiting for start
// RAMP_UP | duty climbs by one per PWM period, 0..PWM_STEPS-1
// HOLD_HI | duty = PWM_STEPS (fully on) for HOLD_PERIODS periods
// RAMP_DN | duty falls by one per PWM period, PWM_STEPS-1..0
// HOLD_LO | duty = 0 (fully off) for HOLD_PERIODS periods, then rotate channel
module led_breath_seq #(
   parameter int CLK_PER_US   = 34,
   parameter int PWM_STEPS    = 1000,
   parameter int HOLD_PERIODS = 200,
   parameter int N_LED        = 4
) (
   input  logic             s_clk,
   input  logic             s_rst,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   output logic [N_LED-1:0] led,
   output logic [N_LED-1:0] ch_sel,
   output logic             busy
);

   localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam int DW = $clog2(PWM_STEPS + 1);
   localparam int HW = $clog2(HOLD_PERIODS + 1);

   localparam logic [PW-1:0]    PRE_MAX   = PW'(CLK_PER_US - 1);
   localparam logic [DW-1:0]    DUTY_FULL = DW'(PWM_STEPS);
   localparam logic [DW-1:0]    CNT_MAX   = DW'(PWM_STEPS - 1);
   localparam logic [HW-1:0]    HOLD_MAX  = HW'(HOLD_PERIODS - 1);
   localparam logic [N_LED-1:0] CH_INIT   = N_LED'(1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RAMP_UP = 3'd1,
      HOLD_HI = 3'd2,
      RAMP_DN = 3'd3,
      HOLD_LO = 3'd4
   } state_t;

   state_t            state, state_nx;
   logic [PW-1:0]     prescaler, prescaler_nx;
   logic [DW-1:0]     pwm_cnt, pwm_cnt_nx;
   logic [DW-1:0]     duty, duty_nx;
   logic [HW-1:0]     hold_cnt, hold_cnt_nx;
   logic              mode_q, mode_q_nx;
   logic [N_LED-1:0]  ch_sel_nx;
   logic [N_LED-1:0]  led_nx;
   logic              tick;
   logic              period_end;
   logic              lit;

   assign tick       = (state != IDLE) && (prescaler == PRE_MAX);
   assign period_end = tick && (pwm_cnt == CNT_MAX);
   assign busy       = (state != IDLE);

`ifdef LED_BREATH_GAMMA_EN
   localparam int GW = 2 * DW;
   logic [GW-1:0] cnt_scaled;
   logic [GW-1:0] duty_sq;
   // Widths chosen so (PWM_STEPS-1)*PWM_STEPS and PWM_STEPS^2 both fit.
   assign cnt_scaled = GW'(pwm_cnt) * GW'(PWM_STEPS);
   assign duty_sq    = GW'(duty) * GW'(duty);
   assign lit        = (cnt_scaled < duty_sq);
`else
   assign lit = (pwm_cnt < duty);
`endif

   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         state     <= IDLE;
         prescaler <= '0;
         pwm_cnt   <= '0;
         duty      <= '0;
         hold_cnt  <= '0;
         mode_q    <= 1'b0;
         ch_sel    <= CH_INIT;
         led       <= '1;
      end else begin
         state     <= state_nx;
         prescaler <= prescaler_nx;
         pwm_cnt   <= pwm_cnt_nx;
         duty      <= duty_nx;
         hold_cnt  <= hold_cnt_nx;
         mode_q    <= mode_q_nx;
         ch_sel    <= ch_sel_nx;
         led       <= led_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      prescaler_nx = prescaler;
      pwm_cnt_nx   = pwm_cnt;
      duty_nx      = duty;
      hold_cnt_nx  = hold_cnt;
      mode_q_nx    = mode_q;
      ch_sel_nx    = ch_sel;
      led_nx       = '1;

      if (state != IDLE) begin
         prescaler_nx = tick ? '0 : prescaler + PW'(1);
         if (tick) begin
            pwm_cnt_nx = (pwm_cnt == CNT_MAX) ? '0 : pwm_cnt + DW'(1);
         end
         // The LED register follows the counters of this cycle, not next.
         led_nx = mode_q ? ~({N_LED{lit}} & ch_sel) : ~{N_LED{lit}};
      end

      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx     = RAMP_UP;
               duty_nx      = '0;
               hold_cnt_nx  = '0;
               mode_q_nx    = mode;
               prescaler_nx = '0;
               pwm_cnt_nx   = '0;
            end
         end
         RAMP_UP: begin
            if (period_end) begin
               if (duty == CNT_MAX) begin
                  state_nx    = HOLD_HI;
                  duty_nx     = DUTY_FULL;
                  hold_cnt_nx = '0;
               end else begin
                  duty_nx = duty + DW'(1);
               end
            end
         end
         HOLD_HI: begin
            if (period_end) begin
               if (hold_cnt == HOLD_MAX) begin
                  state_nx = RAMP_DN;
                  duty_nx  = CNT_MAX;
               end else begin
                  hold_cnt_nx = hold_cnt + HW'(1);
               end
            end
         end
         RAMP_DN: begin
            if (period_end) begin
               if (duty == '0) begin
                  state_nx    = HOLD_LO;
                  hold_cnt_nx = '0;
               end else begin
                  duty_nx = duty - DW'(1);
               end
            end
         end
         HOLD_LO: begin
            if (period_end) begin
               if (hold_cnt == HOLD_MAX) begin
                  state_nx = RAMP_UP;
                  duty_nx  = '0;
                  if (mode_q) begin
                     ch_sel_nx = {ch_sel[N_LED-2:0], ch_sel[N_LED-1]};
                  end
               end else begin
                  hold_cnt_nx = hold_cnt + HW'(1);
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      // Abort takes effect from any state and matches reset exactly.
      if (stop) begin
         state_nx     = IDLE;
         prescaler_nx = '0;
         pwm_cnt_nx   = '0;
         duty_nx      = '0;
         hold_cnt_nx  = '0;
         mode_q_nx    = 1'b0;
         ch_sel_nx    = CH_INIT;
         led_nx       = '1;
      end
   end

endmodule

// File: tb/tb_led_breath_seq.sv
module tb_led_breath_seq;

   localparam int CPU   = 3;
   localparam int STEPS = 10;
   localparam int HOLD  = 2;
   localparam int NL    = 4;
   localparam int PER_CLK    = CPU * STEPS;
   localparam int BREATH_PER = 2 * STEPS + 2 * HOLD;
   localparam int BREATH_CLK = BREATH_PER * PER_CLK;

   logic          s_clk = 1'b0;
   logic          s_rst = 1'b1;
   logic          start = 1'b0;
   logic          stop  = 1'b0;
   logic          mode  = 1'b0;
   logic [NL-1:0] led;
   logic [NL-1:0] ch_sel;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [NL-1:0] led;
      logic [NL-1:0] ch;
      logic          busy;
      string         name;
   } exp_t;

   typedef struct {
      logic          start;
      logic          stop;
      logic          mode;
      int            wait_cyc;
      logic [NL-1:0] led;
      logic [NL-1:0] ch;
      logic          busy;
      string         name;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[10];

   led_breath_seq #(
      .CLK_PER_US  (CPU),
      .PWM_STEPS   (STEPS),
      .HOLD_PERIODS(HOLD),
      .N_LED       (NL)
   ) dut (
      .s_clk (s_clk),
      .s_rst (s_rst),
      .start (start),
      .stop  (stop),
      .mode  (mode),
      .led   (led),
      .ch_sel(ch_sel),
      .busy  (busy)
   );

   always #5 s_clk = ~s_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required earlier finish");
      $fatal(1, "timeout");
   end

   // Duty in force during PWM period p of a breath, from the ramp/hold schedule.
   function automatic int breath_duty(input int p);
      int q;
      q = p % BREATH_PER;
      if (q < STEPS) return q;
      if (q < STEPS + HOLD) return STEPS;
      if (q < 2 * STEPS + HOLD) return 2 * STEPS + HOLD - 1 - q;
      return 0;
   endfunction

   function automatic logic [NL-1:0] ch_at(input int u, input bit m);
      logic [NL-1:0] one;
      one = 1;
      if (!m) return one;
      return one << ((u / BREATH_CLK) % NL);
   endfunction

   // j = cycles after the accepted start edge; led lags the counters by one.
   function automatic exp_t model(input int j, input bit m, input string tag);
      exp_t e;
      int   u, o, d;
      bit   lit;
      e.busy = 1'b1;
      e.ch   = ch_at(j, m);
      e.name = $sformatf("%s_j%0d", tag, j);
      if (j == 0) begin
         e.led = '1;
      end else begin
         u = j - 1;
         o = (u % PER_CLK) / CPU;
         d = breath_duty(u / PER_CLK);
`ifdef LED_BREATH_GAMMA_EN
         lit = (o * STEPS) < (d * d);
`else
         lit = o < d;
`endif
         e.led = m ? ~({NL{lit}} & ch_at(u, m)) : ~{NL{lit}};
      end
      return e;
   endfunction

   task automatic check_out(input string name, input logic [NL-1:0] e_led,
                            input logic [NL-1:0] e_ch, input logic e_busy);
      n_tests++;
      if (led !== e_led || ch_sel !== e_ch || busy !== e_busy) begin
         n_fail++;
         $display("FAIL %s: got led=%b ch_sel=%b busy=%b, required led=%b ch_sel=%b busy=%b",
                  name, led, ch_sel, busy, e_led, e_ch, e_busy);
      end
   endtask

   task automatic check_idle(input string name);
      check_out(name, 4'b1111, 4'b0001, 1'b0);
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(posedge s_clk); #1;
      stop = 1'b0;
   endtask

   task automatic run_seq(input bit m, input int n_cyc, input int extra_start_at,
                          input string tag);
      exp_t e;
      start = 1'b1;
      mode  = m;
      @(posedge s_clk); #1;
      start = 1'b0;
      e = model(0, m, tag);
      check_out(e.name, e.led, e.ch, e.busy);
      for (int j = 1; j <= n_cyc; j++) begin
         mode  = 1'($urandom_range(0, 1));
         start = (j == extra_start_at);
         sb_q.push_back(model(j, m, tag));
         @(posedge s_clk); #1;
         start = 1'b0;
         e = sb_q.pop_front();
         check_out(e.name, e.led, e.ch, e.busy);
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b0, 1'b0,  4, 4'b1111, 4'b0001, 1'b0, "idle_no_start"};
      vecs[1] = '{1'b1, 1'b1, 1'b1,  0, 4'b1111, 4'b0001, 1'b0, "start_stop_same"};
      vecs[2] = '{1'b1, 1'b0, 1'b0,  0, 4'b1111, 4'b0001, 1'b1, "m0_start_busy"};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 30, 4'b0000, 4'b0001, 1'b1, "m0_duty1_lit"};
      vecs[4] = '{1'b0, 1'b1, 1'b0,  0, 4'b1111, 4'b0001, 1'b0, "stop_early"};
      vecs[5] = '{1'b1, 1'b0, 1'b1,  0, 4'b1111, 4'b0001, 1'b1, "m1_start_busy"};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 30, 4'b1110, 4'b0001, 1'b1, "m1_duty1_lit"};
      vecs[7] = '{1'b1, 1'b0, 1'b0,  0, 4'b1110, 4'b0001, 1'b1, "start_while_busy"};
      vecs[8] = '{1'b0, 1'b0, 1'b0,  0, 4'b1110, 4'b0001, 1'b1, "no_restart"};
      vecs[9] = '{1'b0, 1'b1, 1'b0,  0, 4'b1111, 4'b0001, 1'b0, "stop_m1"};

      s_rst = 1'b1;
      repeat (3) @(posedge s_clk);
      #1;
      s_rst = 1'b0;
      check_idle("reset_release");

      foreach (vecs[i]) begin
         start = vecs[i].start;
         stop  = vecs[i].stop;
         mode  = vecs[i].mode;
         @(posedge s_clk); #1;
         start = 1'b0;
         stop  = 1'b0;
         if (vecs[i].wait_cyc > 0) begin
            repeat (vecs[i].wait_cyc) @(posedge s_clk);
            #1;
         end
         check_out(vecs[i].name, vecs[i].led, vecs[i].ch, vecs[i].busy);
      end

      // In-phase breath into the second breath's ramp-down; stray start in HOLD_HI.
      run_seq(1'b0, 1110, 320, "m0");
      pulse_stop();
      check_idle("stop_ramp_dn_m0");

      // Chase over four full breaths so ch_sel wraps back to bit 0.
      run_seq(1'b1, 4 * BREATH_CLK + 20, 0, "m1");
      pulse_stop();
      check_idle("stop_after_wrap");

      // Abort with ch_sel on bit 1; restart must come back on bit 0 at duty 0.
      run_seq(1'b1, 1110, 0, "m1b");
      pulse_stop();
      check_idle("stop_ramp_dn_m1");
      run_seq(1'b1, 100, 0, "m1c");

      s_rst = 1'b1;
      @(posedge s_clk); #1;
      s_rst = 1'b0;
      check_idle("rst_ramp_up");

      run_seq(1'b0, 70, 0, "m0_after_rst");
      pulse_stop();
      check_idle("stop_final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
